// File: rtl/decimation_engine.sv
// decimation_engine: programmable-ratio sample decimator, pick or min/max mode.
// Build option: define DECIM_PEAK_EN to include the peak (min/max) datapath.
module decimation_engine #(
    parameter int CNT_W  = 24,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic [CNT_W-1:0]  Decimation_IN,
    input  logic              MODE,
    input  logic              DATA_VALID,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] OUT_MAX,
    output logic [DATA_W-1:0] OUT_MIN,
    output logic              CLK_EN,
    output logic              BUSY
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              first_q;
    logic              run_q;
    logic              valid_q;
    logic              clk_en_q;
    logic              busy_q;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] res_max_d;
    logic [DATA_W-1:0] res_min_d;
    logic              win_end;

    assign win_end = DATA_VALID && (cnt_q == '0);

`ifdef DECIM_PEAK_EN
    logic              mode_q;
    logic [DATA_W-1:0] acc_max_q;
    logic [DATA_W-1:0] acc_min_q;
    logic [DATA_W-1:0] max_d;
    logic [DATA_W-1:0] min_d;

    // Running extremes including the current sample; a fresh window restarts them
    always_comb begin
        max_d = DATA_IN;
        min_d = DATA_IN;
        if (!first_q) begin
            if (acc_max_q > DATA_IN) max_d = acc_max_q;
            if (acc_min_q < DATA_IN) min_d = acc_min_q;
        end
        res_max_d = mode_q ? max_d : DATA_IN;
        res_min_d = mode_q ? min_d : DATA_IN;
    end
`else
    logic unused_peak;

    // Without the peak datapath every window is a plain pick
    always_comb begin
        res_max_d = DATA_IN;
        res_min_d = DATA_IN;
    end

    assign unused_peak = ^{MODE, first_q};
`endif

    // Input run synchroniser and memory-write enable delay
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            run_q    <= 1'b0;
            clk_en_q <= 1'b0;
        end else begin
            run_q    <= RUN;
            clk_en_q <= valid_q;
        end
    end

    // Window FSM: counts accepted samples and emits one result per window
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            max_q     <= '0;
            min_q     <= '0;
`ifdef DECIM_PEAK_EN
            mode_q    <= 1'b0;
            acc_max_q <= '0;
            acc_min_q <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (run_q) begin
                        cnt_q   <= Decimation_IN;
                        first_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
`ifdef DECIM_PEAK_EN
                        mode_q  <= MODE;
`endif
                    end
                end
                S_RUN: begin
                    if (!run_q) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (DATA_VALID) begin
                        first_q <= 1'b0;
`ifdef DECIM_PEAK_EN
                        acc_max_q <= max_d;
                        acc_min_q <= min_d;
`endif
                        if (win_end) begin
                            valid_q <= 1'b1;
                            max_q   <= res_max_d;
                            min_q   <= res_min_d;
                            cnt_q   <= Decimation_IN;
                            first_q <= 1'b1;
`ifdef DECIM_PEAK_EN
                            mode_q  <= MODE;
`endif
                        end else begin
                            cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign OUT_VALID = valid_q;
    assign OUT_MAX   = max_q;
    assign OUT_MIN   = min_q;
    assign CLK_EN    = clk_en_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_decimation_engine.sv
// tb_decimation_engine: scoreboard bench for decimation_engine.
// Directed windows; expected results queued at stimulus, popped by a monitor.
module tb_decimation_engine;

    localparam int CNT_W  = 24;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run;
    logic [CNT_W-1:0]  dec;
    logic              mode;
    logic              dv;
    logic [DATA_W-1:0] din;
    logic              out_valid;
    logic [DATA_W-1:0] out_max;
    logic [DATA_W-1:0] out_min;
    logic              clk_en;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [15:0] e;
    bit          prev_pop = 1'b0;
    bit          cur_pop;

    decimation_engine #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .RUN          (run),
        .Decimation_IN(dec),
        .MODE         (mode),
        .DATA_VALID   (dv),
        .DATA_IN      (din),
        .OUT_VALID    (out_valid),
        .OUT_MAX      (out_max),
        .OUT_MIN      (out_min),
        .CLK_EN       (clk_en),
        .BUSY         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v, input bit last,
                        input logic [7:0] emax, input logic [7:0] emin);
        dv  = 1'b1;
        din = v;
        if (last) exp_q.push_back({emax, emin});
        tick();
        dv = 1'b0;
    endtask

    task automatic pk(input logic [7:0] v, input bit last);
        send(v, last, v, v);
    endtask

    task automatic start_run(input logic [CNT_W-1:0] d, input logic m);
        dec  = d;
        mode = m;
        run  = 1'b1;
        tick();
        check("busy_pre", busy, 0);
        tick();
        check("busy_on", busy, 1);
    endtask

    task automatic stop_run();
        run = 1'b0;
        tick();
        tick();
        check("busy_off", busy, 0);
        tick();
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pop expected result on each strobe; CLK_EN must trail one cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pop = 1'b0;
        end else begin
            cur_pop = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got max=%0d min=%0d expected none",
                             out_max, out_min);
                end else begin
                    e = exp_q.pop_front();
                    check("out_max", out_max, e[15:8]);
                    check("out_min", out_min, e[7:0]);
                    cur_pop = 1'b1;
                end
            end
            if (prev_pop || clk_en) check("clk_en", clk_en, prev_pop);
            prev_pop = cur_pop;
        end
    end

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        dec   = '0;
        mode  = 1'b0;
        dv    = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_clk_en", clk_en, 0);
        check("rst_busy", busy, 0);
        check("rst_max", out_max, 0);
        check("rst_min", out_min, 0);
        rst_n = 1'b1;
        tick();

        // Pick mode, D=3: results on samples 4, 8, 12
        start_run(3, 1'b0);
        for (int i = 1; i <= 12; i++) pk(i[7:0], (i % 4) == 0);
        drain("pick_drain");
        stop_run();

        // Asynchronous reset mid-window, D=5
        start_run(5, 1'b0);
        pk(1, 1'b0);
        pk(2, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_clk_en", clk_en, 0);
        check("arst_busy", busy, 0);
        check("arst_max", out_max, 0);
        check("arst_min", out_min, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_busy_1", busy, 0);
        tick();
        check("rel_busy_2", busy, 1);
        for (int i = 1; i <= 6; i++) pk(i[7:0], i == 6);
        drain("arst_drain");
        stop_run();

        // Peak mode, D=4
        start_run(4, 1'b1);
        pk(10, 1'b0);
        pk(200, 1'b0);
        pk(3, 1'b0);
        pk(77, 1'b0);
`ifdef DECIM_PEAK_EN
        send(50, 1'b1, 200, 3);
`else
        send(50, 1'b1, 50, 50);
`endif
        for (int i = 1; i <= 5; i++) send(5, i == 5, 5, 5);
        drain("peak_drain");
        stop_run();

        // Ratio change mid-window: D=7 then 1
        start_run(7, 1'b0);
        for (int i = 1; i <= 3; i++) pk(i[7:0], 1'b0);
        dec = 1;
        for (int i = 4; i <= 12; i++) pk(i[7:0], (i == 8) || (i == 10) || (i == 12));
        drain("ratio_drain");
        stop_run();

        // Gapped input, D=2, valid every 3rd cycle
        start_run(2, 1'b0);
        for (int i = 0; i < 9; i++) begin
            pk(8'(20 + i), (i % 3) == 2);
            tick();
            tick();
        end
        drain("gap_drain");
        stop_run();

        // Abort partial window, then a full window is needed
        start_run(9, 1'b0);
        for (int i = 1; i <= 5; i++) pk(i[7:0], 1'b0);
        stop_run();
        check("abort_q", exp_q.size(), 0);
        start_run(9, 1'b0);
        for (int i = 31; i <= 40; i++) pk(i[7:0], i == 40);
        drain("abort_drain");
        stop_run();

        // D=0 pass-through, back-to-back strobes
        start_run(0, 1'b1);
        pk(7, 1'b1);
        pk(9, 1'b1);
        pk(3, 1'b1);
        drain("d0_drain");
        stop_run();

        // RUN falls on the window-end sample: window still completes
        start_run(1, 1'b0);
        pk(50, 1'b0);
        run = 1'b0;
        pk(51, 1'b1);
        tick();
        check("fall_busy", busy, 0);
        drain("fall_drain");

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decimation_engine.md
# decimation_engine

Parametrised successor to the single-mode sample decimation counter. It sits between the ADC capture register and the sample-memory write port. It reduces the input sample stream by a programmable ratio, in either plain pick mode or peak-detect (min/max) mode. Each completed window produces one output strobe plus a one-cycle-delayed clock-enable for the memory writer.

## Interface
- CNT_W, 24: width of the decimation ratio and window counter.
- DATA_W, 8: sample width.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- RUN  in  1  capture enable; level-sensitive, registered once internally (run_q) before use.
- Decimation_IN  in  CNT_W  ratio minus one; value D gives one output per D+1 accepted samples.
- MODE  in  1  0 = pick, 1 = peak (min/max).
- DATA_VALID  in  1  input sample strobe.
- DATA_IN  in  DATA_W  input sample, unsigned.
- OUT_VALID  out  1  one-cycle strobe: window result is on OUT_MAX/OUT_MIN.
- OUT_MAX  out  DATA_W  window maximum; in pick mode, the picked sample.
- OUT_MIN  out  DATA_W  window minimum; in pick mode, equal to OUT_MAX.
- CLK_EN  out  1  OUT_VALID delayed by one cycle; memory write enable.
- BUSY  out  1  high while the FSM is in RUN.

## Operation
- State machine: IDLE, RUN.
- IDLE:
  - Samples are ignored.
  - When run_q=1: load ratio_q←Decimation_IN, mode_q←MODE, cnt←Decimation_IN, first←1, then go to RUN.
- RUN:
  - On each DATA_VALID:
    - If first=1: acc_max←DATA_IN, acc_min←DATA_IN.
    - Otherwise: acc_max←max(acc_max,DATA_IN), acc_min←min(acc_min,DATA_IN) (unsigned compare).
    - first←0.
  - Window end is DATA_VALID with cnt==0. On that cycle:
    - Peak mode: OUT_MAX/OUT_MIN get the max/min including the current sample.
    - Pick mode: OUT_MAX and OUT_MIN both get DATA_IN.
    - OUT_VALID pulses high.
    - cnt←Decimation_IN, mode_q←MODE, first←1.
    - Ratio and mode changes take effect only at window boundaries.
  - DATA_VALID with cnt≠0: cnt←cnt−1, no output.
  - Cycles without DATA_VALID: cnt and accumulators hold.
  - run_q=0: go to IDLE. The partial window is discarded with no OUT_VALID. OUT_MAX/OUT_MIN keep their last values.
- D=0: every accepted sample is a window end (pass-through, both modes).
- D=2^CNT_W−1: no wrap. The counter only decrements from nonzero.
- RUN falling on the same cycle as a window-end sample: run_q is still 1 that cycle, so the window completes and OUT_VALID fires. Leave RUN next cycle.
- Reset at any time: all state is cleared immediately (asynchronous), with no output.

## Timing
- Reset values:
  - OUT_VALID=0, CLK_EN=0, BUSY=0.
  - OUT_MAX=0, OUT_MIN=0.
  - Internally: state=IDLE, cnt=0, run_q=0, first=1.
- RUN↑ sampled at edge t → run_q=1 after t. FSM enters RUN at edge t+1, so BUSY=1 after t+1. The first accepted DATA_VALID is at edge t+2.
- Window-end DATA_VALID at edge t → OUT_VALID=1 and data valid after t, for exactly one cycle. CLK_EN=1 after edge t+1.
- OUT_MAX/OUT_MIN are stable from the OUT_VALID cycle until the next window end.
- Back-to-back windows (D=0, DATA_VALID every cycle) → OUT_VALID continuously high; CLK_EN follows one cycle later.
- RUN↓ → BUSY falls two edges later (run_q stage plus FSM stage).
- Throughput: one sample per clock, no stall, no backpressure.

## Configuration
- DECIM_PEAK_EN:
  - Defined: peak mode is built with comparators and accumulators as described.
  - Undefined: the comparators and acc_max/acc_min are omitted. MODE is ignored and every window behaves as pick mode (OUT_MAX=OUT_MIN=window-end sample). All other behaviour and timing are unchanged.

## Test plan
- Reset check: assert RST=0 mid-window with D=5 → all outputs 0 immediately. Release, RUN=1 → BUSY=1 after 2 edges, first OUT_VALID only after 6 fresh samples.
- Pick mode, D=3, DATA_IN=1,2,3,…,12 each cycle → OUT_VALID on samples 4, 8, 12. OUT_MAX=OUT_MIN=4, 8, 12. CLK_EN one cycle after each.
- Peak mode, D=4, window 10,200,3,77,50 → OUT_MAX=200, OUT_MIN=3. Next window starts fresh with 5,5,5,5,5 → 5/5.
- Ratio change mid-window: D=7, set Decimation_IN=1 after sample 3 → current window still ends at sample 8, then outputs every 2 samples.
- Gapped input, D=2, DATA_VALID every 3rd cycle → OUT_VALID only on every 3rd valid sample. Counter holds between strobes.
- Abort: D=9, drop RUN after 5 samples → no OUT_VALID, BUSY=0. Re-raise RUN → full 10-sample window required. With DECIM_PEAK_EN undefined, rerun the peak case → OUT_MAX=OUT_MIN=50.
